// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: computes a - b - bin LSB-first, one bit per clock, borrow kept in a flop.
// Optional signed-overflow output ovf when SERSUB_OVF_EN is defined.
module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERSUB_OVF_EN
  output logic             bout,
  output logic             ovf
`else
  output logic             bout
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  a_sr;
  logic [WIDTH-1:0]  b_sr;
  logic [WIDTH-1:0]  res_sr;
  logic              brw;
  logic [CntW-1:0]   cnt;

  logic              x;
  logic              y;
  logic              d_bit;
  logic              brw_nxt;
  logic [WIDTH-1:0]  res_nxt;
  logic              last_bit;

`ifdef SERSUB_OVF_EN
  // Operand sign bits, kept because the operand shift registers lose them.
  logic              a_msb;
  logic              b_msb;
`endif

  // Full-subtract cell on the current LSBs.
  always_comb begin
    x        = a_sr[0];
    y        = b_sr[0];
    d_bit    = x ^ y ^ brw;
    brw_nxt  = (~x & y) | (~(x ^ y) & brw);
    res_nxt  = {d_bit, res_sr[WIDTH-1:1]};
    last_bit = (cnt == CntW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      brw     <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
`ifdef SERSUB_OVF_EN
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      ovf     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q <= StShift;
            a_sr    <= a_in;
            b_sr    <= b_in;
            brw     <= bin_in;
            cnt     <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
`ifdef SERSUB_OVF_EN
            a_msb   <= a_in[WIDTH-1];
            b_msb   <= b_in[WIDTH-1];
`endif
          end else begin
            state_q <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b0;
          end
        end
        StShift: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_nxt;
          brw    <= brw_nxt;
          cnt    <= cnt + CntW'(1);
          if (last_bit) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
            diff    <= res_nxt;
            bout    <= brw_nxt;
`ifdef SERSUB_OVF_EN
            ovf     <= (a_msb != b_msb) & (res_nxt[WIDTH-1] != a_msb);
`endif
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
Bit-serial multi-bit subtractor stage built around the 1-bit full-subtract cell. It computes a - b - bin LSB-first, one bit per clock, with the borrow held in a flop between bits. It accepts parallel operands on a start pulse and returns a parallel registered difference plus final borrow. It is the upstream sequencer that feeds the full-subtract cell, scaled to WIDTH bits.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock, single clock domain
rst_n  input  1  synchronous active-low reset, sampled on rising clk edge
start  input  1  request; sampled only when busy=0
a_in  input  WIDTH  minuend, captured on accepted start
b_in  input  WIDTH  subtrahend, captured on accepted start
bin_in  input  1  initial borrow-in, captured on accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse; diff/bout valid from this cycle on
diff  output  WIDTH  registered difference (a - b - bin) mod 2^WIDTH
bout  output  1  registered final borrow-out (1 when a < b + bin, unsigned)

Behaviour:
- Reset: synchronous, active-low. Clock and reset are fixed as above: one clock clk, reset rst_n synchronous active-low. When rst_n=0 at a clock edge: state=IDLE, busy=0, done=0, diff=0, bout=0, bit counter=0, borrow flop=0, internal shift registers=0. Reset overrides start and any in-flight operation. The aborted result is discarded and done is not asserted.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE or DONE with start=1: load a_sr<=a_in, b_sr<=b_in, brw<=bin_in, cnt<=0, go to SHIFT.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE.
- SHIFT, per edge:
  - x=a_sr[0], y=b_sr[0].
  - d = x^y^brw.
  - brw <= (~x&y) | (~(x^y)&brw).
  - d is shifted into the MSB of the result shift register, which shifts right.
  - a_sr and b_sr shift right.
  - cnt <= cnt+1.
- SHIFT exit: on the edge processing the bit where cnt==WIDTH-1, go to DONE. On that same edge, diff<=final result vector (including this bit) and bout<=final brw value.
- busy=1 exactly while state==SHIFT. done=1 exactly while state==DONE.
- Latency: start sampled at edge E0. Bits are processed at edges E1..E_WIDTH. done is high between E_WIDTH and E_WIDTH+1.
- Throughput: a new start can be accepted at E_WIDTH+1 (during DONE), giving a WIDTH+1 cycle minimum period.
- start while busy=1 is ignored. Operands are not re-sampled and the operation is not restarted.
- diff and bout change only on completion (or reset). They hold the last result through the next operation's SHIFT phase.
- Counter width is clog2(WIDTH)+1 bits and never wraps within an operation.
- Arithmetic is unsigned modulo 2^WIDTH. bout=1 iff a_in < b_in + bin_in.

Optional Feature:
Macro SERSUB_OVF_EN.
- When defined, adds output port ovf (1 bit, reset 0).
- ovf is the two's-complement signed overflow flag, registered with diff on completion: ovf = (a[MSB]!=b[MSB]) & (diff[MSB]!=a[MSB]), using the captured operands.
- ovf holds alongside diff until the next completion.
- When not defined, the ovf port and its logic are absent and there is no other behavioural change.

Test Plan:
- WIDTH=8, a_in=8'h5A, b_in=8'h3C, bin_in=0, start pulse at E0 -> busy high E0..E8, done high one cycle after E8, diff=8'h1E, bout=0.
- a_in=8'h00, b_in=8'h01, bin_in=0 -> diff=8'hFF, bout=1. Then a_in=8'hFF, b_in=8'hFF, bin_in=1 -> diff=8'hFF, bout=1.
- Back-to-back: start held high across DONE with a=8'h10, b=8'h01 then a=8'h20, b=8'h02 -> second op accepted during first done cycle, results 8'h0F then 8'h1E, done pulses 9 cycles apart, diff stays 8'h0F throughout the second SHIFT phase.
- start re-pulsed at E3 with different operands during busy -> ignored; result matches the first operands and done occurs exactly once after E8.
- rst_n=0 for one edge at E4 mid-operation -> next cycle busy=0, done=0, diff=0, bout=0, state IDLE, and no done pulse follows.
- With SERSUB_OVF_EN: a=8'h80, b=8'h01, bin=0 -> diff=8'h7F, bout=0, ovf=1. a=8'h05, b=8'h03 -> diff=8'h02, ovf=0.
